// File: rtl/dmem_bank_arbiter_if.sv
// dmem_bank_arbiter_if: core-side and bank-side buses of the data-memory bank arbiter
interface dmem_bank_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BANK_AW = 10,
  parameter int CNT_W = 16
);
  logic [3:0] core_rd, core_wr, core_stall, core_rvalid, bank_en, bank_we;
  logic [4*ADDR_W-1:0] core_addr;
  logic [4*DATA_W-1:0] core_wdata, core_rdata, bank_wdata, bank_rdata;
  logic [4*BANK_AW-1:0] bank_addr;
  logic [4*CNT_W-1:0] conflict_cnt;
  modport slave (
    input core_rd, core_wr, core_addr, core_wdata, bank_rdata,
    output core_stall, core_rdata, core_rvalid, bank_en, bank_we, bank_addr, bank_wdata, conflict_cnt
  );
  modport master (
    output core_rd, core_wr, core_addr, core_wdata, bank_rdata,
    input core_stall, core_rdata, core_rvalid, bank_en, bank_we, bank_addr, bank_wdata, conflict_cnt
  );
endinterface

// File: rtl/dmem_bank_arbiter.sv
// dmem_bank_arbiter: word-interleaved 4-core to 4-bank data arbiter with per-bank round-robin
module dmem_bank_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BANK_AW = 10,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  dmem_bank_arbiter_if.slave bus
);
  logic [3:0] req, grant, gv, pend_v;
  logic [1:0] sel [4];
  logic [3:0] breq [4];
  logic [1:0] rr_ptr [4], gidx [4], pend_core [4];
  logic [CNT_W-1:0] cnt [4];
  always_comb begin
    req = bus.core_rd | bus.core_wr;
    for (int c = 0; c < 4; c++) sel[c] = bus.core_addr[c*ADDR_W+2 +: 2];
    bus.core_rvalid = '0;
    bus.core_rdata = '0;
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 4; c++) breq[b][c] = req[c] && sel[c] == 2'(b);
      gv[b] = 1'b0;
      gidx[b] = '0;
      // scan from the far end so the requester closest to rr_ptr wins; grants are held off in reset
      for (int k = 3; k >= 0; k--)
        if (breq[b][rr_ptr[b]+2'(k)]) begin
          gv[b] = rst;
          gidx[b] = rr_ptr[b] + 2'(k);
        end
      bus.bank_en[b] = gv[b];
      bus.bank_we[b] = gv[b] & bus.core_wr[gidx[b]];
      bus.bank_addr[b*BANK_AW +: BANK_AW] = gv[b] ? bus.core_addr[gidx[b]*ADDR_W+4 +: BANK_AW] : '0;
      bus.bank_wdata[b*DATA_W +: DATA_W] = gv[b] ? bus.core_wdata[gidx[b]*DATA_W +: DATA_W] : '0;
      bus.conflict_cnt[b*CNT_W +: CNT_W] = cnt[b];
      if (pend_v[b]) begin
        bus.core_rvalid[pend_core[b]] = 1'b1;
        bus.core_rdata[pend_core[b]*DATA_W +: DATA_W] = bus.bank_rdata[b*DATA_W +: DATA_W];
      end
    end
    for (int c = 0; c < 4; c++) grant[c] = gv[sel[c]] && gidx[sel[c]] == 2'(c);
    bus.core_stall = req & ~grant;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pend_v <= '0;
      for (int b = 0; b < 4; b++) begin
        rr_ptr[b] <= '0;
        pend_core[b] <= '0;
        cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (gv[b]) rr_ptr[b] <= gidx[b] + 2'd1;
        pend_v[b] <= gv[b] & ~bus.core_wr[gidx[b]];
        pend_core[b] <= gidx[b];
        if ($countones(breq[b]) > 1 && ~&cnt[b]) cnt[b] <= cnt[b] + 1'b1;
      end
    end
endmodule

// File: tb/tb_dmem_bank_arbiter.sv
// tb_dmem_bank_arbiter: directed bench with bank memory model and read-response scoreboard
module tb_dmem_bank_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  dmem_bank_arbiter_if bus ();
  dmem_bank_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {logic [3:0] rv; logic [127:0] rd;} exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;
  logic [31:0] mem [4][1024];
  logic wrote [4][1024];
  logic [31:0] rdq [4];
  function automatic logic [31:0] iw(int b, int a);
    return 32'hA500_0000 | (b << 16) | a;
  endfunction
  function automatic logic [127:0] w(int c, logic [31:0] d);
    return {96'b0, d} << (c * 32);
  endfunction
  // synchronous single-port banks; unwritten words read back a fixed per-location pattern
  always @(posedge clk)
    for (int b = 0; b < 4; b++) begin
      if (bus.bank_en[b] && bus.bank_we[b]) begin
        mem[b][bus.bank_addr[b*10 +: 10]] <= bus.bank_wdata[b*32 +: 32];
        wrote[b][bus.bank_addr[b*10 +: 10]] <= 1'b1;
      end else if (bus.bank_en[b])
        rdq[b] <= (wrote[b][bus.bank_addr[b*10 +: 10]] === 1'b1) ? mem[b][bus.bank_addr[b*10 +: 10]]
                                                                 : iw(b, int'(bus.bank_addr[b*10 +: 10]));
    end
  assign bus.bank_rdata = {rdq[3], rdq[2], rdq[1], rdq[0]};
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    bus.core_rd = '0;
    bus.core_wr = '0;
    bus.core_addr = '0;
    bus.core_wdata = '0;
  endtask
  task automatic setc(int c, logic r, logic wr, logic [31:0] a, logic [31:0] d);
    bus.core_rd[c] = r;
    bus.core_wr[c] = wr;
    bus.core_addr[c*32 +: 32] = a;
    bus.core_wdata[c*32 +: 32] = d;
  endtask
  task automatic settle();
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("rvalid", bus.core_rvalid, e.rv);
      chk("rdata", bus.core_rdata, e.rd);
    end
  endtask
  task automatic adv(logic [3:0] rv, logic [127:0] rd);
    sb.push_back('{rv, rd});
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    idle();
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.push_back('{4'b0, 128'b0});
  endtask
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
  initial begin
    idle();
    setc(0, 1, 0, 0, 0);
    setc(1, 1, 0, 0, 0);
    #2;
    chk("rst_stall", bus.core_stall, 4'b0011);
    chk("rst_en", bus.bank_en, 4'b0);
    chk("rst_we", bus.bank_we, 4'b0);
    chk("rst_rvalid", bus.core_rvalid, 4'b0);
    chk("rst_cnt", bus.conflict_cnt, 64'b0);
    do_reset();
    // no conflict: one core per bank
    for (int c = 0; c < 4; c++) setc(c, 1, 0, 32'(4 * c), 0);
    settle();
    chk("t1_stall", bus.core_stall, 4'b0);
    chk("t1_en", bus.bank_en, 4'hF);
    chk("t1_we", bus.bank_we, 4'h0);
    chk("t1_addr", bus.bank_addr, 40'b0);
    adv(4'hF, {iw(3, 0), iw(2, 0), iw(1, 0), iw(0, 0)});
    idle();
    settle();
    adv(4'h0, 128'b0);
    // full conflict on bank 0, each core drops once served
    do_reset();
    for (int c = 0; c < 4; c++) setc(c, 1, 0, 32'h10, 0);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t2_stall", bus.core_stall, 4'(4'b1110 << i));
      chk("t2_addr", bus.bank_addr[9:0], 10'd1);
      adv(4'(1 << i), w(i, iw(0, 1)));
      setc(i, 0, 0, 0, 0);
    end
    settle();
    chk("t2_cnt", bus.conflict_cnt[15:0], 16'd3);
    adv(4'h0, 128'b0);
    // round-robin between cores 1 and 3 on bank 2
    setc(1, 0, 1, 32'h8, 32'h11);
    setc(3, 0, 1, 32'h18, 32'h33);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t3_stall", bus.core_stall, (i % 2 == 0) ? 4'b1000 : 4'b0010);
      chk("t3_we", bus.bank_we, 4'b0100);
      chk("t3_addr", bus.bank_addr[29:20], (i % 2 == 0) ? 10'd0 : 10'd1);
      chk("t3_wdata", bus.bank_wdata[95:64], (i % 2 == 0) ? 32'h11 : 32'h33);
      adv(4'h0, 128'b0);
    end
    idle();
    settle();
    chk("t3_cnt", bus.conflict_cnt[47:32], 16'd4);
    adv(4'h0, 128'b0);
    // read-after-write; the read uses ignored upper and byte-offset bits
    setc(0, 0, 1, 32'h24, 32'hDEADBEEF);
    settle();
    chk("t4_stall", bus.core_stall, 4'b0);
    chk("t4_en", bus.bank_en, 4'b0010);
    chk("t4_we", bus.bank_we, 4'b0010);
    chk("t4_addr", bus.bank_addr[19:10], 10'd2);
    chk("t4_wdata", bus.bank_wdata[63:32], 32'hDEADBEEF);
    adv(4'h0, 128'b0);
    setc(0, 1, 0, 32'hF000_0027, 0);
    settle();
    chk("t4_ren", bus.bank_en, 4'b0010);
    chk("t4_rwe", bus.bank_we, 4'b0000);
    chk("t4_raddr", bus.bank_addr[19:10], 10'd2);
    adv(4'b0001, w(0, 32'hDEADBEEF));
    idle();
    settle();
    adv(4'h0, 128'b0);
    // read and write together behave as a write
    setc(2, 1, 1, 32'h30, 32'h5);
    settle();
    chk("t5_en", bus.bank_en, 4'b0001);
    chk("t5_we", bus.bank_we, 4'b0001);
    chk("t5_addr", bus.bank_addr[9:0], 10'd3);
    chk("t5_wdata", bus.bank_wdata[31:0], 32'h5);
    adv(4'h0, 128'b0);
    idle();
    settle();
    adv(4'h0, 128'b0);
    // reset while a read is pending
    do_reset();
    setc(1, 1, 0, 32'h0, 0);
    setc(2, 1, 0, 32'h0, 0);
    settle();
    chk("t6_stall", bus.core_stall, 4'b0100);
    @(posedge clk);
    #1;
    chk("t6_pend", bus.core_rvalid, 4'b0010);
    chk("t6_cnt1", bus.conflict_cnt[15:0], 16'd1);
    rst = 1'b0;
    #1;
    chk("t6_rvalid", bus.core_rvalid, 4'b0);
    chk("t6_rdata", bus.core_rdata, 128'b0);
    chk("t6_cnt0", bus.conflict_cnt, 64'b0);
    chk("t6_rst_stall", bus.core_stall, 4'b0110);
    chk("t6_rst_en", bus.bank_en, 4'b0);
    idle();
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.push_back('{4'b0, 128'b0});
    for (int c = 0; c < 4; c++) setc(c, 1, 0, 32'h0, 0);
    settle();
    chk("t6_first", bus.core_stall, 4'b1110);
    adv(4'b0001, w(0, iw(0, 0)));
    idle();
    settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
